// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, row reset pattern.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Indexed by {row, col}; entry 0 (row 0, col 0) is the rightmost nibble.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [1:0] first_low(input logic [3:0] cols);
      casez (cols)
         4'b???0: return 2'd0;
         4'b??01: return 2'd1;
         4'b?011: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus CPU register port; the scanner uses the slave view.
interface keypad_scanner_if;
   logic [3:0] rowwrite;
   logic [3:0] colread;
   logic       statusordata;
   logic       ack;
   logic [3:0] keyout;

   modport master (input rowwrite, keyout, output colread, statusordata, ack);
   modport slave  (output rowwrite, keyout, input colread, statusordata, ack);
endinterface

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for the asynchronous column inputs; idles high (no key).
module keypad_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] cols_async,
   output logic [3:0] cols_sync
);

   logic [3:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta      <= 4'hF;
         cols_sync <= 4'hF;
      end else begin
         meta      <= cols_async;
         cols_sync <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce and a CPU status/data register; ready clears on ack.
// Optional KEYPAD_DEBOUNCE_EN: when undefined, a single sample accepts a press or a release.
module keypad_scanner #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4
) (
   input logic             clk,
   input logic             rst,
   keypad_scanner_if.slave bus
);
   import keypad_pkg::*;

`ifdef KEYPAD_DEBOUNCE_EN
   localparam int NEED = DEBOUNCE_CNT;
`else
   localparam int NEED = 1;
`endif
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(NEED + 1);

   state_t         state;
   logic [DW-1:0]  div;
   logic [1:0]     row;
   logic [3:0]     rows;
   logic [1:0]     col;
   logic [CW-1:0]  cnt;
   logic [3:0]     code;
   logic           ready;
   logic [3:0]     cols;

   keypad_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .cols_async (bus.colread),
      .cols_sync  (cols)
   );

   logic sample;
   logic any_low;
   logic same_col;

   assign sample   = (div == DW'(SCAN_DIV - 1));
   assign any_low  = ~&cols;
   assign same_col = any_low && (first_low(cols) == col);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SCAN;
         div   <= '0;
         row   <= '0;
         rows  <= ROW_RESET;
         col   <= '0;
         cnt   <= '0;
         code  <= '0;
         ready <= 1'b0;
      end else begin
         div <= sample ? '0 : div + DW'(1);
         // Clear first so a press accepted on the same edge still sets ready.
         if (bus.ack) ready <= 1'b0;
         if (sample) begin
            case (state)
               SCAN: begin
                  if (any_low) begin
                     col <= first_low(cols);
                     if (NEED == 1) begin
                        code  <= KEY_MAP[{row, first_low(cols)}];
                        ready <= 1'b1;
                        cnt   <= '0;
                        state <= RELEASE;
                     end else begin
                        cnt   <= CW'(1);
                        state <= DEBOUNCE;
                     end
                  end else begin
                     row  <= row + 2'd1;
                     rows <= {rows[2:0], rows[3]};
                  end
               end
               DEBOUNCE: begin
                  if (same_col) begin
                     if (cnt == CW'(NEED - 1)) begin
                        code  <= KEY_MAP[{row, col}];
                        ready <= 1'b1;
                        cnt   <= '0;
                        state <= RELEASE;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end else begin
                     state <= SCAN;
                     row   <= row + 2'd1;
                     rows  <= {rows[2:0], rows[3]};
                  end
               end
               RELEASE: begin
                  if (any_low) begin
                     cnt <= '0;
                  end else if (cnt == CW'(NEED - 1)) begin
                     cnt   <= '0;
                     state <= SCAN;
                     row   <= row + 2'd1;
                     rows  <= {rows[2:0], rows[3]};
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

   assign bus.rowwrite = rows;
   assign bus.keyout   = bus.statusordata ? {3'b000, ready} : code;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a virtual keypad matrix driven from rowwrite, checked against the key table and timing rules.
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DC = 2;
`ifdef KEYPAD_DEBOUNCE_EN
   localparam int EFF = DC;
`else
   localparam int EFF = 1;
`endif
   localparam int PRESS_BUDGET   = 2 + 4*SD + EFF*SD + 3*SD;
   localparam int RELEASE_BUDGET = (EFF + 2)*SD + 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   bit   pressed [16];
   int   key_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   keypad_scanner_if bus();

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row to its column; undriven columns float high.
   always_comb begin
      logic [3:0] c;
      c = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            if (pressed[r*4 + k] && !bus.rowwrite[r]) c[k] = 1'b0;
      bus.colread = c;
   end

   function automatic logic [3:0] row_pat(input int r);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << (r % 4));
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic read_views(output logic [3:0] s, output logic [3:0] d);
      bus.statusordata = 1'b1;
      #1 s = bus.keyout;
      bus.statusordata = 1'b0;
      #1 d = bus.keyout;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      bus.statusordata = 1'b1;
      for (int i = 0; i < PRESS_BUDGET && !ok; i++) begin
         @(negedge clk);
         #1 if (bus.keyout[0] === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_row(input logic [3:0] pat, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (bus.rowwrite === pat) ok = 1'b1;
      end
   endtask

   task automatic release_all(input int r, output bit ok);
      foreach (pressed[i]) pressed[i] = 1'b0;
      wait_row(row_pat(r + 1), RELEASE_BUDGET, ok);
   endtask

   task automatic ack_pulse;
      @(negedge clk) bus.ack = 1'b1;
      @(negedge clk) bus.ack = 1'b0;
   endtask

   task automatic test_reset;
      logic [3:0] s, d;
      cycles(7);
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus.rowwrite !== 4'b1110) begin
         bad++; $display("FAIL reset_row got=%b exp=1110", bus.rowwrite);
      end
      read_views(s, d);
      total++;
      if (s !== 4'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", s); end
      total++;
      if (d !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", d); end
      @(negedge clk) rst = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         total++;
         if (bus.rowwrite !== row_pat(n / SD)) begin
            bad++; $display("FAIL rotate_n%0d got=%b exp=%b", n, bus.rowwrite, row_pat(n / SD));
         end
      end
   endtask

   task automatic test_single_press;
      logic [3:0] s, d;
      bit ok;
      pressed[1*4 + 2] = 1'b1;
      wait_ready(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL single_timeout got=no_ready exp=ready"); end
      read_views(s, d);
      total++;
      if (s !== 4'h1) begin bad++; $display("FAIL single_status got=%h exp=1", s); end
      total++;
      if (d !== 4'(key_tab[6])) begin bad++; $display("FAIL single_code got=%h exp=%h", d, key_tab[6]); end
      total++;
      if (bus.rowwrite !== row_pat(1)) begin bad++; $display("FAIL single_frozen got=%b exp=%b", bus.rowwrite, row_pat(1)); end
      release_all(1, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL single_resume got=%b exp=%b", bus.rowwrite, row_pat(2)); end
      ack_pulse();
   endtask

   task automatic test_ack;
      logic [3:0] s, d;
      bit ok;
      pressed[3*4 + 1] = 1'b1;
      wait_ready(ok);
      read_views(s, d);
      total++;
      if (!ok || s !== 4'h1 || d !== 4'(key_tab[13])) begin
         bad++; $display("FAIL ack_press got=%h/%h exp=1/%h", s, d, key_tab[13]);
      end
      ack_pulse();
      read_views(s, d);
      total++;
      if (s !== 4'h0) begin bad++; $display("FAIL ack_clear got=%h exp=0", s); end
      total++;
      if (d !== 4'(key_tab[13])) begin bad++; $display("FAIL ack_data got=%h exp=%h", d, key_tab[13]); end
      ack_pulse();
      ack_pulse();
      read_views(s, d);
      total++;
      if (s !== 4'h0) begin bad++; $display("FAIL ack_repeat got=%h exp=0", s); end
      release_all(3, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ack_resume got=%b exp=%b", bus.rowwrite, row_pat(0)); end
   endtask

   task automatic test_bounce;
      logic [3:0] s, d;
      bit ok;
      logic [3:0] exp_s;
      exp_s = (EFF == 1) ? 4'h1 : 4'h0;
      wait_row(row_pat(3), 6*SD, ok);
      wait_row(row_pat(0), 2*SD, ok);
      pressed[0] = 1'b1;
      cycles(SD);
      total++;
      if (bus.rowwrite !== 4'b1110) begin bad++; $display("FAIL bounce_freeze got=%b exp=1110", bus.rowwrite); end
      pressed[0] = 1'b0;
      wait_row(row_pat(1), 4*SD, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL bounce_resume got=%b exp=%b", bus.rowwrite, row_pat(1)); end
      read_views(s, d);
      total++;
      if (s !== exp_s) begin bad++; $display("FAIL bounce_ready got=%h exp=%h", s, exp_s); end
      ack_pulse();
   endtask

   task automatic test_priority;
      logic [3:0] s, d;
      bit ok;
      int hits, moved;
      pressed[2*4 + 0] = 1'b1;
      pressed[2*4 + 3] = 1'b1;
      wait_ready(ok);
      read_views(s, d);
      total++;
      if (!ok || d !== 4'(key_tab[8])) begin bad++; $display("FAIL prio_code got=%h exp=%h", d, key_tab[8]); end
      ack_pulse();
      hits = 0;
      moved = 0;
      bus.statusordata = 1'b1;
      repeat (20*SD) begin
         @(negedge clk);
         #1;
         if (bus.keyout[0] !== 1'b0) hits++;
         if (bus.rowwrite !== row_pat(2)) moved++;
      end
      total++;
      if (hits !== 0) begin bad++; $display("FAIL prio_repeat got=%0d exp=0", hits); end
      total++;
      if (moved !== 0) begin bad++; $display("FAIL prio_frozen got=%0d exp=0", moved); end
      release_all(2, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL prio_resume got=%b exp=%b", bus.rowwrite, row_pat(3)); end
   endtask

   task automatic test_overrun;
      logic [3:0] s, d;
      bit ok;
      int k;
      pressed[1*4 + 1] = 1'b1;
      wait_ready(ok);
      release_all(1, ok);
      pressed[2*4 + 2] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < PRESS_BUDGET && !ok; i++) begin
         @(negedge clk);
         read_views(s, d);
         if (d === 4'(key_tab[10])) ok = 1'b1;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL overrun_code got=%h exp=%h", d, key_tab[10]); end
      total++;
      if (s !== 4'h1) begin bad++; $display("FAIL overrun_ready got=%h exp=1", s); end
      bus.ack = 1'b1;
      release_all(2, ok);
      read_views(s, d);
      total++;
      if (s !== 4'h0) begin bad++; $display("FAIL held_ack_clear got=%h exp=0", s); end
      do k = $urandom_range(0, 15); while (key_tab[k] == key_tab[10]);
      pressed[k] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < PRESS_BUDGET + 4*SD && !ok; i++) begin
         @(negedge clk);
         read_views(s, d);
         if (d === 4'(key_tab[k])) ok = 1'b1;
      end
      total++;
      if (!ok || s !== 4'h1) begin bad++; $display("FAIL collide_set got=%h exp=1 key=%0d", s, k); end
      @(negedge clk);
      read_views(s, d);
      total++;
      if (s !== 4'h0) begin bad++; $display("FAIL collide_next got=%h exp=0", s); end
      bus.ack = 1'b0;
      release_all(k / 4, ok);
   endtask

   task automatic test_random_presses;
      logic [3:0] s, d;
      bit ok;
      int k;
      for (int it = 0; it < 8; it++) begin
         k = $urandom_range(0, 15);
         pressed[k] = 1'b1;
         wait_ready(ok);
         read_views(s, d);
         total++;
         if (!ok || s !== 4'h1 || d !== 4'(key_tab[k]) || bus.rowwrite !== row_pat(k / 4)) begin
            bad++; $display("FAIL rand_press%0d got=%h/%h/%b exp=1/%h/%b", it, s, d, bus.rowwrite, key_tab[k], row_pat(k / 4));
         end
         cycles($urandom_range(0, 3*SD));
         if ($urandom_range(0, 1) == 1) ack_pulse();
         release_all(k / 4, ok);
         total++;
         if (!ok) begin bad++; $display("FAIL rand_resume%0d got=%b exp=%b", it, bus.rowwrite, row_pat(k / 4 + 1)); end
         ack_pulse();
      end
   endtask

   task automatic test_reset_abort;
      logic [3:0] s, d;
      bit ok;
      pressed[1*4 + 0] = 1'b1;
      wait_ready(ok);
      #1 rst = 1'b1;
      #1;
      read_views(s, d);
      total++;
      if (bus.rowwrite !== 4'b1110 || s !== 4'h0 || d !== 4'h0) begin
         bad++; $display("FAIL abort_state got=%b/%h/%h exp=1110/0/0", bus.rowwrite, s, d);
      end
      foreach (pressed[i]) pressed[i] = 1'b0;
      @(negedge clk) rst = 1'b0;
      cycles(SD);
      total++;
      if (bus.rowwrite !== row_pat(1)) begin bad++; $display("FAIL abort_rotate got=%b exp=%b", bus.rowwrite, row_pat(1)); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.statusordata = 1'b0;
      bus.ack = 1'b0;
      foreach (pressed[i]) pressed[i] = 1'b0;
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      test_reset();
      test_single_press();
      test_ack();
      test_bounce();
      test_priority();
      test_overrun();
      test_random_presses();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
